// File: rtl/ring_router_buf.sv
// Buffered ring router between a cluster's slide unit and its left/right ring neighbours.
// Each ring input has its own FIFO and each ring output has a single-entry register.
// Configuration is accepted only while idle, and three saturating counters track traffic.
module ring_router_buf #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 conf_valid_i,
    output logic                 conf_ready_o,
    input  logic                 conf_dir_i,
    input  logic                 conf_bypass_i,
    input  logic [DataWidth-1:0] sldu_i,
    input  logic                 sldu_valid_i,
    output logic                 sldu_ready_o,
    output logic [DataWidth-1:0] sldu_o,
    output logic                 sldu_valid_o,
    input  logic                 sldu_ready_i,
    input  logic [DataWidth-1:0] ring_right_i,
    input  logic                 ring_right_valid_i,
    output logic                 ring_right_ready_o,
    input  logic [DataWidth-1:0] ring_left_i,
    input  logic                 ring_left_valid_i,
    output logic                 ring_left_ready_o,
    output logic [DataWidth-1:0] ring_right_o,
    output logic                 ring_right_valid_o,
    input  logic                 ring_right_ready_i,
    output logic [DataWidth-1:0] ring_left_o,
    output logic                 ring_left_valid_o,
    input  logic                 ring_left_ready_i,
    output logic                 busy_o,
    output logic [CntWidth-1:0]  inj_cnt_o,
    output logic [CntWidth-1:0]  ej_cnt_o,
    output logic [CntWidth-1:0]  fwd_cnt_o
);

    localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned OccWidth = $clog2(FifoDepth + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(FifoDepth - 1);
    localparam logic [OccWidth-1:0] FullOcc = OccWidth'(FifoDepth);

    // Index 0 is the right-hand side, index 1 the left-hand side, for inputs and outputs alike.
    logic                 dir_q, bypass_q;
    logic [DataWidth-1:0] fifo_mem [2][FifoDepth];
    logic [PtrWidth-1:0]  rd_ptr_q [2];
    logic [PtrWidth-1:0]  wr_ptr_q [2];
    logic [OccWidth-1:0]  occ_q [2];
    logic [1:0]           fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DataWidth-1:0] fifo_head [2];
    logic [DataWidth-1:0] in_data [2];
    logic [1:0]           in_valid, in_ready;
    logic [1:0]           out_valid_q;
    logic [DataWidth-1:0] out_data_q [2];
    logic [1:0]           out_ready, out_free, out_load;
    logic [DataWidth-1:0] out_load_data [2];
    logic                 up, down;
    logic                 inj_fire, ej_fire, fwd_fire, conf_fire, busy;
    logic [CntWidth-1:0]  inj_cnt_q, ej_cnt_q, fwd_cnt_q;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign in_data[0]  = ring_right_i;
    assign in_data[1]  = ring_left_i;
    assign in_valid    = {ring_left_valid_i, ring_right_valid_i};
    assign out_ready   = {ring_left_ready_i, ring_right_ready_i};

    assign ring_right_ready_o = in_ready[0];
    assign ring_left_ready_o  = in_ready[1];
    assign ring_right_o       = out_data_q[0];
    assign ring_right_valid_o = out_valid_q[0];
    assign ring_left_o        = out_data_q[1];
    assign ring_left_valid_o  = out_valid_q[1];

    assign busy         = !(&fifo_empty) || (|out_valid_q);
    assign busy_o       = busy;
    assign conf_ready_o = !busy;
    assign conf_fire    = conf_valid_i && !busy;

    assign inj_cnt_o = inj_cnt_q;
    assign ej_cnt_o  = ej_cnt_q;
    assign fwd_cnt_o = fwd_cnt_q;

    // Per-side FIFO and output register status.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fifo_full[i]  = (occ_q[i] == FullOcc);
            fifo_empty[i] = (occ_q[i] == '0);
            fifo_head[i]  = fifo_mem[i][rd_ptr_q[i]];
            out_free[i]   = !out_valid_q[i] || out_ready[i];
        end
    end

    // Routing: upstream FIFO head goes to the SLDU or, in bypass, straight downstream.
    always_comb begin
        in_ready         = '0;
        fifo_push        = '0;
        fifo_pop         = '0;
        out_load         = '0;
        out_load_data[0] = '0;
        out_load_data[1] = '0;
        sldu_o           = '0;
        sldu_valid_o     = 1'b0;
        sldu_ready_o     = 1'b0;
        inj_fire         = 1'b0;
        ej_fire          = 1'b0;
        fwd_fire         = 1'b0;
        // dir=0: right input feeds left output; dir=1: left input feeds right output.
        up               = dir_q;
        down             = ~dir_q;

        in_ready[up]  = !fifo_full[up];
        fifo_push[up] = in_valid[up] && !fifo_full[up];

        if (bypass_q) begin
            if (!fifo_empty[up] && out_free[down]) begin
                fifo_pop[up]        = 1'b1;
                out_load[down]      = 1'b1;
                out_load_data[down] = fifo_head[up];
                fwd_fire            = 1'b1;
            end
        end else begin
            sldu_valid_o        = !fifo_empty[up];
            sldu_o              = fifo_empty[up] ? '0 : fifo_head[up];
            ej_fire             = !fifo_empty[up] && sldu_ready_i;
            fifo_pop[up]        = ej_fire;
            sldu_ready_o        = out_free[down];
            inj_fire            = sldu_valid_i && out_free[down];
            out_load[down]      = inj_fire;
            out_load_data[down] = sldu_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (fifo_push[i]) wr_ptr_q[i] <= next_ptr(wr_ptr_q[i]);
                if (fifo_pop[i])  rd_ptr_q[i] <= next_ptr(rd_ptr_q[i]);
                if (fifo_push[i] && !fifo_pop[i]) begin
                    occ_q[i] <= occ_q[i] + OccWidth'(1);
                end else if (!fifo_push[i] && fifo_pop[i]) begin
                    occ_q[i] <= occ_q[i] - OccWidth'(1);
                end
            end
        end
    end

    // FIFO storage; contents are never observed while the entry is invalid.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (fifo_push[i]) fifo_mem[i][wr_ptr_q[i]] <= in_data[i];
        end
    end

    // Output registers; data returns to zero when the entry drains so idle links stay quiet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q   <= '0;
            out_data_q[0] <= '0;
            out_data_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (out_load[i]) begin
                    out_valid_q[i] <= 1'b1;
                    out_data_q[i]  <= out_load_data[i];
                end else if (out_ready[i]) begin
                    out_valid_q[i] <= 1'b0;
                    out_data_q[i]  <= '0;
                end
            end
        end
    end

    // Configuration and saturating counters; an accepted config clears the counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir_q     <= 1'b0;
            bypass_q  <= 1'b0;
            inj_cnt_q <= '0;
            ej_cnt_q  <= '0;
            fwd_cnt_q <= '0;
        end else if (conf_fire) begin
            dir_q     <= conf_dir_i;
            bypass_q  <= conf_bypass_i;
            inj_cnt_q <= '0;
            ej_cnt_q  <= '0;
            fwd_cnt_q <= '0;
        end else begin
            if (inj_fire && (inj_cnt_q != '1)) inj_cnt_q <= inj_cnt_q + CntWidth'(1);
            if (ej_fire && (ej_cnt_q != '1))   ej_cnt_q  <= ej_cnt_q + CntWidth'(1);
            if (fwd_fire && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + CntWidth'(1);
        end
    end

endmodule
